// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential 32-bit ALU with a valid/ready request and result
// handshake.
//
// Operations (ALUOp):
//   000 add  001 sub  010 and  011 or
//   100 logical right shift    101 arithmetic right shift
//   110/111 illegal, result 0
//
// Add/sub/and/or/illegal finish one cycle after acceptance. Shifts step one
// bit per cycle through CALC (B[4:0] cycles) and then land in DONE, so the
// result appears B[4:0]+1 cycles after acceptance. A zero shift amount skips
// CALC entirely.
//
// Build option:
//   ALU_SEQ_FAST_SHIFT_EN  when defined, shifts are done by a single-cycle
//                          barrel shifter and CALC is never entered. Results
//                          are identical; only the latency changes.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset; abandons any operation in flight
//   in_valid   request offered on A, B, ALUOp
//   in_ready   high only in IDLE
//   A, B       operands; B[4:0] is the shift amount, B[31:5] unused for shifts
//   ALUOp      operation select
//   out_valid  C holds a result (DONE)
//   out_ready  consumer takes the result
//   C          result, held stable in DONE and retained outside it
//   busy       high in CALC or DONE
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] C,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] c_reg, c_next;

    logic [4:0]  sh_amt;
    logic [31:0] direct_result;

    assign sh_amt = B[4:0];

    // Result of everything that can be produced on the acceptance edge.
    always_comb begin
        direct_result = 32'd0;
        case (ALUOp)
            3'b000: direct_result = A + B;
            3'b001: direct_result = A - B;
            3'b010: direct_result = A & B;
            3'b011: direct_result = A | B;
`ifdef ALU_SEQ_FAST_SHIFT_EN
            3'b100: direct_result = A >> sh_amt;
            3'b101: direct_result = $unsigned($signed(A) >>> sh_amt);
`else
            // The iterative build only takes a shift straight to DONE when
            // the amount is zero, in which case the result is A itself.
            3'b100,
            3'b101: direct_result = A;
`endif
            default: direct_result = 32'd0;
        endcase
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    // Latched operands for the iterative shifter. a_reg is shifted in place,
    // cnt_reg counts the remaining single-bit steps.
    logic [31:0] a_reg, a_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        arith_reg, arith_next;
    logic        is_shift;
    logic [31:0] a_step;

    assign is_shift = (ALUOp[2:1] == 2'b10);

    // One-bit right shift of the working operand.
    generate
        for (genvar gi = 0; gi < 31; gi++) begin : g_step
            assign a_step[gi] = a_reg[gi + 1];
        end
    endgenerate
    // Arithmetic fill repeats bit 31, which never changes while shifting
    // arithmetically, so it is always the latched A[31].
    assign a_step[31] = arith_reg ? a_reg[31] : 1'b0;
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
`ifndef ALU_SEQ_FAST_SHIFT_EN
        a_next     = a_reg;
        cnt_next   = cnt_reg;
        arith_next = arith_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
                    a_next     = A;
                    cnt_next   = sh_amt;
                    arith_next = ALUOp[0];
                    if (is_shift && (sh_amt != 5'd0)) begin
                        state_next = CALC;
                    end else begin
                        state_next = DONE;
                        c_next     = direct_result;
                    end
`else
                    state_next = DONE;
                    c_next     = direct_result;
`endif
                end
            end
            CALC: begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
                a_next   = a_step;
                cnt_next = cnt_reg - 5'd1;
                // The last step writes the result directly so DONE starts
                // with C already valid.
                if (cnt_reg == 5'd1) begin
                    state_next = DONE;
                    c_next     = a_step;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
        C         = c_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            c_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
        end
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg     <= 32'd0;
            cnt_reg   <= 5'd0;
            arith_reg <= 1'b0;
        end else begin
            a_reg     <= a_next;
            cnt_reg   <= cnt_next;
            arith_reg <= arith_next;
        end
    end
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  request offered on A, B, ALUOp.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 A  input  32  operand A.
REQ-007 B  input  32  operand B; B[4:0] is the shift amount for shift ops.
REQ-008 ALUOp  input  3  000 add, 001 sub, 010 and, 011 or, 100 logical right shift, 101 arithmetic right shift, 110/111 illegal.
REQ-009 out_valid  output  1  result on C is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 C  output  32  result.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a clock edge, latching A, B, and ALUOp.
REQ-015 Add, sub, and, or, and illegal ops SHALL go IDLE->DONE, with out_valid high in the cycle after acceptance.
REQ-016 Shift ops SHALL go IDLE->CALC, shift one bit per cycle for B[4:0] cycles, then go to DONE; out_valid SHALL rise B[4:0]+1 cycles after acceptance.
REQ-017 A shift with B[4:0]=0 SHALL go IDLE->DONE directly, with C=A after 1 cycle.
REQ-018 Operand bits B[31:5] SHALL be ignored for shifts.
REQ-019 Logical shift SHALL fill with 0; arithmetic shift SHALL fill with the latched A[31].
REQ-020 Add and sub SHALL be modulo 2^32, with no carry or overflow output.
REQ-021 Illegal ops 110/111 SHALL produce C=0.
REQ-022 In DONE, out_valid=1 and C SHALL stay stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle as a result handshake; in_ready rises the cycle after.
REQ-024 in_valid during CALC/DONE SHALL be ignored, with no queueing.
REQ-025 out_valid SHALL be 0 in IDLE and CALC; C SHALL hold its last value outside DONE.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE, with in_ready=1, out_valid=0, busy=0, C=0, and the shift counter and latched operands at 0.
REQ-027 Reset during CALC or DONE SHALL abandon the operation with no result emitted; reset has priority over all handshakes.

Configuration
REQ-028 Macro ALU_SEQ_FAST_SHIFT_EN SHALL select the shift implementation.
- Defined: shifts SHALL complete in one cycle, like non-shift ops (IDLE->DONE, out_valid 1 cycle after acceptance), and CALC SHALL never be entered.
- Undefined: the iterative behaviour of REQ-016/017 SHALL apply.
- Results SHALL be identical in both builds; only latency differs.

Verification
REQ-029 A=2, B=1, out_ready=1, ops 000..011 in sequence -> C=3, 1, 0, 3, each with out_valid 1 cycle after acceptance.
REQ-030 A=0x80000000, B=4, op 100 -> C=0x08000000 at 5 cycles after acceptance; op 101 -> C=0xF8000000 (1 cycle when ALU_SEQ_FAST_SHIFT_EN is defined).
REQ-031 A=0x12345678, B=0xFFFFFFE0, op 101 -> shift amount 0, C=0x12345678, 1 cycle after acceptance.
REQ-032 Op 001, A=0, B=1, out_ready held 0 for 3 cycles -> C=0xFFFFFFFF stable with out_valid=1 throughout, in_ready=0; after out_ready=1, IDLE and in_ready=1 next cycle.
REQ-033 Op 110 -> C=0 after 1 cycle; in_valid asserted during busy -> no acceptance, no extra result.
REQ-034 Op 100, B=31, reset asserted at cycle 10 of CALC -> next cycle IDLE, out_valid=0, C=0, busy=0; no result emitted.
